// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: definitions shared by the store buffer and its neighbours.
//   STORE_BUF_DEPTH  default number of queued entries
//   SB_ADDR_W        default byte-address width
//   SB_DATA_W        entry data width (one 32-bit word, byte-lane aligned)
//   SB_BE_W          byte-enable width, shared with the byte-enable generator
//   sb_merge_bytes() replaces the enabled byte lanes of a word
package store_buffer_pkg;

  localparam int STORE_BUF_DEPTH = 4;
  localparam int SB_ADDR_W       = 32;
  localparam int SB_DATA_W       = 32;
  localparam int SB_BE_W         = 4;

  // Overlay the byte lanes of new_d selected by be onto old_d.
  function automatic logic [SB_DATA_W-1:0] sb_merge_bytes(
    input logic [SB_DATA_W-1:0] old_d,
    input logic [SB_DATA_W-1:0] new_d,
    input logic [SB_BE_W-1:0]   be
  );
    logic [SB_DATA_W-1:0] res;
    res = old_d;
    for (int b = 0; b < SB_BE_W; b++) begin
      res[8*b +: 8] = be[b] ? new_d[8*b +: 8] : old_d[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// store_buffer_if: store, load-forwarding and memory-drain signals of the
// store buffer.
//   master modport: MEM stage / memory side (drives st_*, ld_addr, mem_ready)
//   slave  modport: the store buffer (drives st_stall, ld_fwd_*, mem_*, empty)
interface store_buffer_if
  import store_buffer_pkg::*;
#(
  parameter int ADDR_W = SB_ADDR_W
);
  logic                 st_valid;
  logic [ADDR_W-1:0]    st_addr;
  logic [SB_DATA_W-1:0] st_wdata;
  logic [SB_BE_W-1:0]   st_be;
  logic                 st_stall;
  logic [ADDR_W-1:0]    ld_addr;
  logic [SB_DATA_W-1:0] ld_fwd_data;
  logic [SB_BE_W-1:0]   ld_fwd_mask;
  logic                 mem_valid;
  logic [ADDR_W-1:0]    mem_addr;
  logic [SB_DATA_W-1:0] mem_wdata;
  logic [SB_BE_W-1:0]   mem_be;
  logic                 mem_ready;
  logic                 empty;

  modport master (
    output st_valid, st_addr, st_wdata, st_be, ld_addr, mem_ready,
    input  st_stall, ld_fwd_data, ld_fwd_mask, mem_valid, mem_addr,
           mem_wdata, mem_be, empty
  );

  modport slave (
    input  st_valid, st_addr, st_wdata, st_be, ld_addr, mem_ready,
    output st_stall, ld_fwd_data, ld_fwd_mask, mem_valid, mem_addr,
           mem_wdata, mem_be, empty
  );
endinterface

// File: rtl/store_buffer_fwd.sv
// store_buf_fwd: combinational store-to-load forwarding over the queued
// entries. For every byte lane the youngest valid entry whose word address
// matches and whose byte enable is set supplies the byte.
//   ent_addr_i/ent_data_i/ent_be_i  entry arrays
//   head_i, count_i                 oldest entry index and number of entries
//   ld_waddr_i                      load word address
//   fwd_data_o, fwd_mask_o          forwarded bytes (0 outside mask), lane mask
module store_buf_fwd
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = STORE_BUF_DEPTH,
  parameter int WA_W  = SB_ADDR_W - 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic [WA_W-1:0]      ent_addr_i [DEPTH],
  input  logic [SB_DATA_W-1:0] ent_data_i [DEPTH],
  input  logic [SB_BE_W-1:0]   ent_be_i   [DEPTH],
  input  logic [PTR_W-1:0]     head_i,
  input  logic [CNT_W-1:0]     count_i,
  input  logic [WA_W-1:0]      ld_waddr_i,
  output logic [SB_DATA_W-1:0] fwd_data_o,
  output logic [SB_BE_W-1:0]   fwd_mask_o
);

  logic [PTR_W-1:0] idx_s;
  logic             hit_s;

  // Walk oldest to youngest so a younger hit overwrites an older one per lane.
  always_comb begin
    fwd_data_o = {SB_DATA_W{1'b0}};
    fwd_mask_o = {SB_BE_W{1'b0}};
    idx_s      = head_i;
    hit_s      = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      idx_s = head_i + PTR_W'(k);
      hit_s = (CNT_W'(k) < count_i) && (ent_addr_i[idx_s] == ld_waddr_i);
      for (int b = 0; b < SB_BE_W; b++) begin
        fwd_data_o[8*b +: 8] = (hit_s && ent_be_i[idx_s][b]) ?
                               ent_data_i[idx_s][8*b +: 8] : fwd_data_o[8*b +: 8];
        fwd_mask_o[b]        = (hit_s && ent_be_i[idx_s][b]) ? 1'b1 : fwd_mask_o[b];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: MEM-stage FIFO of lane-aligned stores, drained to the
// byte-enabled data memory over a valid/ready handshake, with byte-granular
// store-to-load forwarding.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         store_buffer_if.slave (st_*, ld_*, mem_*, empty)
// Optional build macro STORE_BUF_COALESCE_EN: a store to the same word as the
// youngest entry merges into it instead of allocating a new entry.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = STORE_BUF_DEPTH,
  parameter int ADDR_W = SB_ADDR_W
) (
  input logic           clk,
  input logic           rst_n,
  store_buffer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WA_W  = ADDR_W - 2;

  logic [WA_W-1:0]      addr_q [DEPTH];
  logic [SB_DATA_W-1:0] data_q [DEPTH];
  logic [SB_BE_W-1:0]   be_q   [DEPTH];
  logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic                 st_req_s, full_s, nonempty_s, pop_s, push_s, coal_s;
  logic [PTR_W-1:0]     young_s, wr_idx_s;
  logic                 wr_en_s;
  logic [SB_DATA_W-1:0] wr_data_s;
  logic [SB_BE_W-1:0]   wr_be_s;
  logic                 unused_ok_s;

  assign unused_ok_s = ^{bus.st_addr[1:0], bus.ld_addr[1:0]};

  // Request decode: push/pop/stall, plus the optional merge into the youngest entry.
  always_comb begin
    st_req_s   = bus.st_valid && (bus.st_be != {SB_BE_W{1'b0}});
    full_s     = (count_q == CNT_W'(DEPTH));
    nonempty_s = (count_q != {CNT_W{1'b0}});
    pop_s      = nonempty_s && bus.mem_ready;
    young_s    = tail_q - PTR_W'(1);
`ifdef STORE_BUF_COALESCE_EN
    // A lone head entry that is leaving this cycle cannot absorb the store.
    coal_s     = st_req_s && nonempty_s &&
                 (addr_q[young_s] == bus.st_addr[ADDR_W-1:2]) &&
                 !((count_q == CNT_W'(1)) && pop_s);
`else
    coal_s     = 1'b0;
`endif
    // Space freed by a same-cycle pop is not reused until the next cycle.
    push_s     = st_req_s && !coal_s && !full_s;
  end

  // Entry write data: either a fresh entry at tail or a merge into the youngest.
  always_comb begin
    wr_en_s = push_s || coal_s;
    if (coal_s) begin
      wr_idx_s  = young_s;
      wr_data_s = sb_merge_bytes(data_q[young_s], bus.st_wdata, bus.st_be);
      wr_be_s   = be_q[young_s] | bus.st_be;
    end else begin
      wr_idx_s  = tail_q;
      wr_data_s = bus.st_wdata;
      wr_be_s   = bus.st_be;
    end
  end

  // Pointer and occupancy next state.
  always_comb begin
    head_d  = pop_s  ? head_q + PTR_W'(1) : head_q;
    tail_d  = push_s ? tail_q + PTR_W'(1) : tail_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/occupancy registers; reset discards every queued store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= {PTR_W{1'b0}};
      tail_q  <= {PTR_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= {WA_W{1'b0}};
        data_q[i] <= {SB_DATA_W{1'b0}};
        be_q[i]   <= {SB_BE_W{1'b0}};
      end
    end else if (wr_en_s) begin
      addr_q[wr_idx_s] <= bus.st_addr[ADDR_W-1:2];
      data_q[wr_idx_s] <= wr_data_s;
      be_q[wr_idx_s]   <= wr_be_s;
    end
  end

  store_buf_fwd #(
    .DEPTH (DEPTH),
    .WA_W  (WA_W)
  ) u_fwd (
    .ent_addr_i (addr_q),
    .ent_data_i (data_q),
    .ent_be_i   (be_q),
    .head_i     (head_q),
    .count_i    (count_q),
    .ld_waddr_i (bus.ld_addr[ADDR_W-1:2]),
    .fwd_data_o (bus.ld_fwd_data),
    .fwd_mask_o (bus.ld_fwd_mask)
  );

  // Head fields come straight from the registered entry; gated to 0 when empty.
  assign bus.mem_valid = nonempty_s;
  assign bus.mem_addr  = nonempty_s ? {addr_q[head_q], 2'b00} : {ADDR_W{1'b0}};
  assign bus.mem_wdata = nonempty_s ? data_q[head_q] : {SB_DATA_W{1'b0}};
  assign bus.mem_be    = nonempty_s ? be_q[head_q] : {SB_BE_W{1'b0}};
  assign bus.empty     = !nonempty_s;
  assign bus.st_stall  = st_req_s && !coal_s && full_s;

endmodule
